// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encoding and default screen/paddle geometry.
// Optional feature macro: BALL_SPEEDUP_EN (paddle hits raise horizontal speed).
package pong_pkg;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StServeWait = 2'd1;
    localparam logic [1:0] StPlay      = 2'd2;
    localparam logic [1:0] StHold      = 2'd3;

    localparam int DEF_CW           = 10;
    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_BALL_HALF    = 2;
    localparam int DEF_SPEED        = 2;
    localparam int DEF_MAX_SPEED    = 6;
    localparam int DEF_PAD_L_X      = 20;
    localparam int DEF_PAD_R_X      = 612;
    localparam int DEF_PAD_W        = 8;
    localparam int DEF_PAD_H        = 48;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_HOLD_FRAMES  = 90;

`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP_EN = 1'b1;
`else
    localparam bit SPEEDUP_EN = 1'b0;
`endif

endpackage

// File: rtl/ball_collide.sv
// Combinational ball step: applies velocity, resolves wall/paddle bounces and flags goals.
// Horizontal speed ceiling depends on BALL_SPEEDUP_EN (via pong_pkg::SPEEDUP_EN).
module ball_collide
    import pong_pkg::*;
#(
    parameter int CW        = DEF_CW,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int BALL_HALF = DEF_BALL_HALF,
    parameter int SPEED     = DEF_SPEED,
    parameter int MAX_SPEED = DEF_MAX_SPEED,
    parameter int PAD_L_X   = DEF_PAD_L_X,
    parameter int PAD_R_X   = DEF_PAD_R_X,
    parameter int PAD_W     = DEF_PAD_W,
    parameter int PAD_H     = DEF_PAD_H
) (
    input  logic [CW-1:0]        x,
    input  logic [CW-1:0]        y,
    input  logic signed [CW+1:0] vx,
    input  logic signed [CW+1:0] vy,
    input  logic [CW-1:0]        paddle_l_y,
    input  logic [CW-1:0]        paddle_r_y,
    output logic [CW-1:0]        next_x,
    output logic [CW-1:0]        next_y,
    output logic signed [CW+1:0] next_vx,
    output logic signed [CW+1:0] next_vy,
    output logic                 goal_l,
    output logic                 goal_r
);
    typedef logic signed [CW+1:0] sval_t;

    // Without speed-up the ceiling equals the serve speed, so |vx| never grows.
    localparam int VX_CEIL = SPEEDUP_EN ? MAX_SPEED : SPEED;

    localparam sval_t BH       = sval_t'(BALL_HALF);
    localparam sval_t L_FACE   = sval_t'(PAD_L_X + PAD_W);
    localparam sval_t R_FACE   = sval_t'(PAD_R_X - 1);
    localparam sval_t Y_MAX_S  = sval_t'(V_ACTIVE - 1 - BALL_HALF);
    localparam sval_t X_GOAL   = sval_t'(H_ACTIVE - 1);
    localparam sval_t PAD_SPAN = sval_t'(PAD_H - 1);
    localparam sval_t CEIL     = sval_t'(VX_CEIL);
    localparam sval_t ZERO     = sval_t'(0);

    localparam logic [CW-1:0] X_L_HIT = CW'(PAD_L_X + PAD_W + BALL_HALF);
    localparam logic [CW-1:0] X_R_HIT = CW'(PAD_R_X - 1 - BALL_HALF);
    localparam logic [CW-1:0] Y_TOP   = CW'(BALL_HALF);
    localparam logic [CW-1:0] Y_BOT   = CW'(V_ACTIVE - 1 - BALL_HALF);

    sval_t sx, sy, nx, ny, pl, pr, ax, ay, ax_hit;
    logic  hit_l, hit_r;

    assign sx = sval_t'({2'b00, x});
    assign sy = sval_t'({2'b00, y});
    assign pl = sval_t'({2'b00, paddle_l_y});
    assign pr = sval_t'({2'b00, paddle_r_y});
    assign nx = sx + vx;
    assign ny = sy + vy;
    assign ax = vx[CW+1] ? -vx : vx;
    assign ay = vy[CW+1] ? -vy : vy;
    assign ax_hit = (ax < CEIL) ? ax + sval_t'(1) : ax;

    // A paddle only reflects a ball crossing its inner face this frame.
    assign hit_l = (vx < ZERO) && (sx - BH >= L_FACE) && (nx - BH < L_FACE) &&
                   (ny + BH >= pl) && (ny - BH <= pl + PAD_SPAN);
    assign hit_r = (vx > ZERO) && (sx + BH <= R_FACE) && (nx + BH > R_FACE) &&
                   (ny + BH >= pr) && (ny - BH <= pr + PAD_SPAN);

    always_comb begin
        next_x  = x;
        next_y  = y;
        next_vx = vx;
        next_vy = vy;
        goal_l  = 1'b0;
        goal_r  = 1'b0;

        if (ny < BH) begin
            next_y  = Y_TOP;
            next_vy = ay;
        end else if (ny > Y_MAX_S) begin
            next_y  = Y_BOT;
            next_vy = -ay;
        end else begin
            next_y = ny[CW-1:0];
        end

        if (hit_l) begin
            next_x  = X_L_HIT;
            next_vx = ax_hit;
        end else if (hit_r) begin
            next_x  = X_R_HIT;
            next_vx = -ax_hit;
        end else if (nx - BH <= ZERO) begin
            goal_r = 1'b1;
        end else if (nx + BH >= X_GOAL) begin
            goal_l = 1'b1;
        end else begin
            next_x = nx[CW-1:0];
        end
    end

endmodule

// File: rtl/ball_engine.sv
// Pong ball controller: frame tick, serve/play/score FSM, ball motion and ball pixel output.
// Optional feature macro: BALL_SPEEDUP_EN (handled inside ball_collide).
module ball_engine
    import pong_pkg::*;
#(
    parameter int CW           = DEF_CW,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int BALL_HALF    = DEF_BALL_HALF,
    parameter int SPEED        = DEF_SPEED,
    parameter int MAX_SPEED    = DEF_MAX_SPEED,
    parameter int PAD_L_X      = DEF_PAD_L_X,
    parameter int PAD_R_X      = DEF_PAD_R_X,
    parameter int PAD_W        = DEF_PAD_W,
    parameter int PAD_H        = DEF_PAD_H,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] hcount,
    input  logic [CW-1:0] vcount,
    input  logic          vsync,
    input  logic [CW-1:0] paddle_l_y,
    input  logic [CW-1:0] paddle_r_y,
    input  logic          serve,
    output logic          r,
    output logic          g,
    output logic          b,
    output logic [CW-1:0] ball_x,
    output logic [CW-1:0] ball_y,
    output logic          score_l,
    output logic          score_r,
    output logic          busy
);
    localparam int CNT_MAX = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0]       X_CTR      = CW'(H_ACTIVE / 2);
    localparam logic [CW-1:0]       Y_CTR      = CW'(V_ACTIVE / 2);
    localparam logic signed [CW+1:0] SPD       = (CW+2)'(SPEED);
    localparam logic signed [CW:0]  PIX_H      = (CW+1)'(BALL_HALF);

    logic                 vsync_d, tick;
    logic [1:0]           state;
    logic [CNT_W-1:0]     frame_cnt;
    logic signed [CW+1:0] vx, vy;

    logic [CW-1:0]        nxt_x, nxt_y;
    logic signed [CW+1:0] nxt_vx, nxt_vy;
    logic                 goal_l, goal_r;

    logic signed [CW:0]   dx, dy;
    logic                 in_ball;

    assign tick = vsync_d & ~vsync;
    assign busy = (state != StIdle);

    assign dx      = $signed({1'b0, hcount}) - $signed({1'b0, ball_x});
    assign dy      = $signed({1'b0, vcount}) - $signed({1'b0, ball_y});
    assign in_ball = (dx >= -PIX_H) && (dx <= PIX_H) && (dy >= -PIX_H) && (dy <= PIX_H);

    ball_collide #(
        .CW        (CW),
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .BALL_HALF (BALL_HALF),
        .SPEED     (SPEED),
        .MAX_SPEED (MAX_SPEED),
        .PAD_L_X   (PAD_L_X),
        .PAD_R_X   (PAD_R_X),
        .PAD_W     (PAD_W),
        .PAD_H     (PAD_H)
    ) u_collide (
        .x          (ball_x),
        .y          (ball_y),
        .vx         (vx),
        .vy         (vy),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .next_x     (nxt_x),
        .next_y     (nxt_y),
        .next_vx    (nxt_vx),
        .next_vy    (nxt_vy),
        .goal_l     (goal_l),
        .goal_r     (goal_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_d   <= 1'b0;
            state     <= StIdle;
            frame_cnt <= '0;
            ball_x    <= X_CTR;
            ball_y    <= Y_CTR;
            vx        <= SPD;
            vy        <= SPD;
            score_l   <= 1'b0;
            score_r   <= 1'b0;
            r         <= 1'b0;
            g         <= 1'b0;
            b         <= 1'b0;
        end else begin
            vsync_d <= vsync;
            score_l <= 1'b0;
            score_r <= 1'b0;
            r       <= in_ball;
            g       <= in_ball;
            b       <= in_ball;
            if (tick) begin
                case (state)
                    StIdle: begin
                        if (serve) begin
                            state     <= StServeWait;
                            frame_cnt <= '0;
                            vx        <= vx[CW+1] ? -SPD : SPD;
                        end
                    end
                    StServeWait: begin
                        if (frame_cnt == SERVE_LAST) begin
                            state     <= StPlay;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    StPlay: begin
                        // On a goal the ball freezes where it was; the loser receives the serve.
                        if (goal_l || goal_r) begin
                            state     <= StHold;
                            frame_cnt <= '0;
                            score_l   <= goal_l;
                            score_r   <= goal_r;
                            vx        <= goal_l ? -SPD : SPD;
                            vy        <= SPD;
                        end else begin
                            ball_x <= nxt_x;
                            ball_y <= nxt_y;
                            vx     <= nxt_vx;
                            vy     <= nxt_vy;
                        end
                    end
                    StHold: begin
                        if (frame_cnt == HOLD_LAST) begin
                            state     <= StIdle;
                            frame_cnt <= '0;
                            ball_x    <= X_CTR;
                            ball_y    <= Y_CTR;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: per-frame scoreboard fed by a behavioural ball model.
module tb_ball_engine;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset, vsync, serve;
    logic [CW-1:0] hcount, vcount, paddle_l_y, paddle_r_y;
    logic          r, g, b, score_l, score_r, busy;
    logic [CW-1:0] ball_x, ball_y;

    ball_engine dut (
        .clk        (clk),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .vsync      (vsync),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .serve      (serve),
        .r          (r),
        .g          (g),
        .b          (b),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          busy;
        logic          sl;
        logic          sr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   seen_l = 0;
    int   seen_r = 0;

    // Model state: 0 idle, 1 serve wait, 2 play, 3 hold.
    int m_x = 320, m_y = 240, m_vx = 2, m_vy = 2, m_st = 0, m_cnt = 0;
    int m_gl = 0, m_gr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_tick(input logic srv);
        int nx, ny, ax, ay, sp, pl, pr;
        bit hl, hr;
        m_gl = 0;
        m_gr = 0;
        pl = int'(paddle_l_y);
        pr = int'(paddle_r_y);
        case (m_st)
            0: if (srv) begin m_st = 1; m_cnt = 0; m_vx = (m_vx < 0) ? -2 : 2; end
            1: if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end else m_cnt++;
            2: begin
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                ax = (m_vx < 0) ? -m_vx : m_vx;
                ay = (m_vy < 0) ? -m_vy : m_vy;
                hl = (m_vx < 0) && (m_x - 2 >= 28) && (nx - 2 < 28) &&
                     (ny + 2 >= pl) && (ny - 2 <= pl + 47);
                hr = (m_vx > 0) && (m_x + 2 <= 611) && (nx + 2 > 611) &&
                     (ny + 2 >= pr) && (ny - 2 <= pr + 47);
                if (!hl && !hr && nx - 2 <= 0) m_gr = 1;
                else if (!hl && !hr && nx + 2 >= 639) m_gl = 1;
                if (m_gl || m_gr) begin
                    m_st = 3;
                    m_cnt = 0;
                    m_vx = m_gl ? -2 : 2;
                    m_vy = 2;
                end else begin
                    if (ny < 2) begin m_y = 2; m_vy = ay; end
                    else if (ny > 477) begin m_y = 477; m_vy = -ay; end
                    else m_y = ny;
                    sp = ax;
`ifdef BALL_SPEEDUP_EN
                    if (ax < 6) sp = ax + 1;
`endif
                    if (hl) begin m_x = 30; m_vx = sp; end
                    else if (hr) begin m_x = 609; m_vx = -sp; end
                    else m_x = nx;
                end
            end
            default: if (m_cnt == 89) begin m_st = 0; m_cnt = 0; m_x = 320; m_y = 240; end
                     else m_cnt++;
        endcase
    endtask

    // One frame: vsync falls for one clock, outputs sampled after the tick edge.
    task automatic do_tick(input logic srv);
        exp_t e;
        @(negedge clk);
        vsync = 1'b0;
        serve = srv;
        model_tick(srv);
        e.x = m_x[CW-1:0];
        e.y = m_y[CW-1:0];
        e.busy = (m_st != 0);
        e.sl = (m_gl != 0);
        e.sr = (m_gr != 0);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("ball_x", ball_x, e.x);
        chk("ball_y", ball_y, e.y);
        chk("busy", busy, e.busy);
        chk("score_l", score_l, e.sl);
        chk("score_r", score_r, e.sr);
        if (score_l) seen_l++;
        if (score_r) seen_r++;
        vsync = 1'b1;
        @(negedge clk);
        chk("score_l_pulse_end", score_l, 0);
        chk("score_r_pulse_end", score_r, 0);
    endtask

    task automatic rally();
        int px, py, pvx, pvy;
        for (int i = 0; i < 1000; i++) begin
            px = m_x; py = m_y; pvx = m_vx; pvy = m_vy;
            do_tick(1'b0);
            if (py == 3 && pvy < 0) chk("top_wall_y", ball_y, 2);
            if (py == 476 && pvy > 0) chk("bottom_wall_y", ball_y, 477);
            if (px == 31 && pvx < 0 && m_vx > 0) chk("left_paddle_x", ball_x, 30);
            if (px == 608 && pvx > 0 && m_vx < 0) chk("right_paddle_x", ball_x, 609);
            if (px == 30 && pvx < 0 && paddle_l_y == 10'd300) chk("left_miss_x", ball_x, 28);
            if (m_st == 3) break;
        end
    endtask

    task automatic pix(input int h, input int v, input logic exp);
        @(negedge clk);
        hcount = h[CW-1:0];
        vcount = v[CW-1:0];
        @(negedge clk);
        chk("pix_r", r, exp);
        chk("pix_g", g, exp);
        chk("pix_b", b, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; vsync = 1'b1; serve = 1'b0;
        hcount = '0; vcount = '0;
        paddle_l_y = 10'd150; paddle_r_y = 10'd400;
        repeat (3) @(negedge clk);
        chk("rst_ball_x", ball_x, 320);
        chk("rst_ball_y", ball_y, 240);
        chk("rst_busy", busy, 0);
        chk("rst_r", r, 0);
        chk("rst_score_l", score_l, 0);
        chk("rst_score_r", score_r, 0);
        reset = 1'b0;

        // Ball square around (320,240) is 317..323 exclusive edges at +-3.
        pix(320, 240, 1'b1);
        pix(322, 242, 1'b1);
        pix(318, 238, 1'b1);
        pix(323, 240, 1'b0);
        pix(317, 240, 1'b0);
        pix(320, 243, 1'b0);
        pix(320, 237, 1'b0);
        pix(0, 0, 1'b0);

        // Serve held high through the wait must be ignored.
        do_tick(1'b1);
        repeat (60) do_tick(1'b1);
        chk("serve_wait_x", ball_x, 320);
        chk("play_busy", busy, 1);
        do_tick(1'b0);
        chk("launch_x", ball_x, 322);
        chk("launch_y", ball_y, 242);
        pix(324, 244, 1'b1);

        rally();
        chk("phase_a_score_l_count", seen_l, 1);
        repeat (5) do_tick(1'b1);
        repeat (85) do_tick(1'b0);
        chk("hold_exit_x", ball_x, 320);
        chk("hold_exit_y", ball_y, 240);
        chk("hold_exit_busy", busy, 0);

        paddle_l_y = 10'd300;
        do_tick(1'b1);
        repeat (60) do_tick(1'b0);
        do_tick(1'b0);
        chk("serve_to_loser_x", ball_x, 318);
        rally();
        chk("phase_b_score_r_count", seen_r, 1);
        repeat (90) do_tick(1'b0);

        do_tick(1'b1);
        repeat (60) do_tick(1'b0);
        repeat (5) do_tick(1'b0);
        @(negedge clk);
        hcount = m_x[CW-1:0];
        vcount = m_y[CW-1:0];
        @(negedge clk);
        chk("pre_reset_r", r, 1);
        reset = 1'b1;
        vsync = 1'b0;
        @(negedge clk);
        chk("midplay_rst_x", ball_x, 320);
        chk("midplay_rst_y", ball_y, 240);
        chk("midplay_rst_busy", busy, 0);
        chk("midplay_rst_r", r, 0);
        chk("midplay_rst_g", g, 0);
        chk("midplay_rst_b", b, 0);
        chk("midplay_rst_score_l", score_l, 0);
        chk("midplay_rst_score_r", score_r, 0);
        reset = 1'b0;
        vsync = 1'b1;
        m_x = 320; m_y = 240; m_vx = 2; m_vy = 2; m_st = 0; m_cnt = 0;
        do_tick(1'b0);
        chk("final_score_l_count", seen_l, 1);
        chk("final_score_r_count", seen_r, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
